regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: successor to the 32x32, 2-read/1-write CPU register file. It adds configurable width, depth and port counts, plus multiple write ports with fixed priority. A per-register busy scoreboard supports pipelined issue/writeback, and write-to-read bypass is optional. It sits between decode (reads, issue) and writeback (writes) in the CPU datapath.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (≥2, need not be a power of two); AW = $clog2(DEPTH)
- NREAD, 2, read ports (1..4)
- NWRITE, 2, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high
- RAddr  in  NREAD x AW  read addresses
- RData  out  NREAD x WIDTH  read data, combinational
- RBusy  out  NREAD  scoreboard bit of RAddr[i], combinational
- WE  in  NWRITE  write enables
- WAddr  in  NWRITE x AW  write addresses
- WData  in  NWRITE x WIDTH  write data
- IssueEn  in  1  mark IssueRd busy (instruction issued with a pending result)
- IssueRd  in  AW  destination being issued
- AnyBusy  out  1  OR of all busy bits

## Operation
- Storage: DEPTH x WIDTH registers and DEPTH busy bits.
- Reset (async assert): all registers 0 and all busy bits 0. While Rst is high: RData = 0, RBusy = 0, AnyBusy = 0.
- Write: on a rising edge with WE[j]=1, register WAddr[j] takes WData[j].
  - Writes to address ≥ DEPTH are ignored.
  - Writes to address 0 are ignored when ZERO_REG=1.
- Write conflict: two ports write the same address in one cycle → highest port index wins; the other write is dropped.
- Read: RData[i] = Rfile[RAddr[i]].
  - Returns 0 if RAddr[i] ≥ DEPTH.
  - Returns 0 if ZERO_REG=1 and RAddr[i]=0.
- Scoreboard, evaluated per edge:
  - Any accepted write to address a clears busy[a].
  - IssueEn sets busy[IssueRd].
  - Set has priority over clear on the same address, because a new producer supersedes the old one.
  - Issue to address ≥ DEPTH is ignored; issue to 0 is ignored when ZERO_REG=1.
  - An issue to an already-busy register keeps it busy (no counting).
- RBusy[i] = busy[RAddr[i]], with the same out-of-range and zero rules (reports 0).

## Timing
- Write latency: data visible on RData in the cycle after the write edge (no bypass build).
- Issue latency: RBusy/AnyBusy go high in the cycle after the IssueEn edge.
- Clear latency: busy drops in the cycle after the write edge.
- Reads are purely combinational from state and ports; there is no read enable.
- Reset deasserting mid-sequence: the first edge after deassert performs normal writes and issues.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Same-cycle bypass: if any WE[j] targets RAddr[i] (valid, non-zero-reg address), RData[i] = WData of the winning port.
  - RBusy[i] reads 0 for that address unless IssueEn targets it in the same cycle.
  - Zero-latency read-after-write.
- Not defined: no bypass; reads return stored state only and RBusy reflects the registered busy bit.

## Structure
- Package regfile_pkg: default WIDTH/DEPTH constants, an addr-width function wrapping $clog2, and the zero-register index constant.
- Sub-module regfile_scoreboard: busy-bit array with set/clear priority, RBusy lookup and AnyBusy. It takes the winning write addresses, IssueEn/IssueRd and RAddr.
- Top module holds the data array, write-priority resolution and read muxing/bypass.

## Test plan
- Reset: write x5=0xDEADBEEF, then pulse Rst asynchronously mid-cycle → RData=0 immediately; after release, reading x5 gives 0 and AnyBusy=0.
- Dual write: WE=2'b11, WAddr={3,4}, WData={7,9} → next cycle x3=7, x4=9.
- Conflict: both ports write x6 with {0x11 on port0, 0x22 on port1} → x6 reads 0x22.
- Zero register: write 0xFFFF_FFFF to x0 with ZERO_REG=1 → x0 reads 0; IssueEn on x0 → AnyBusy stays 0.
- Scoreboard:
  - IssueEn on x7 → RBusy=1 next cycle.
  - Write x7 → RBusy=0 next cycle.
  - Issue and write x7 in the same cycle → stays busy.
- Bypass (REGFILE_BYPASS_EN): RAddr0=8 with WE0, WAddr0=8, WData0=42 → RData0=42 in the same cycle. Without the macro → old value in the same cycle, 42 in the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_IDX  = 0;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Address is architecturally writable/trackable: in range and not the hardwired zero register.
  function automatic logic addr_ok(input int a, input int depth, input logic zero_reg);
    return (a < depth) && !(zero_reg && (a == ZERO_IDX));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on the same address.
// REGFILE_BYPASS_EN: a same-cycle write to the read address masks its busy bit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_w(DEF_DEPTH)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NWRITE-1:0]   WrOk,
  input  logic [NWRITE*AW-1:0] WrAddr,
  input  logic                IssueEn,
  input  logic [AW-1:0]       IssueRd,
  input  logic [NREAD*AW-1:0] RAddr,
  output logic [NREAD-1:0]    RBusy,
  output logic                AnyBusy
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             issue_ok;
  logic [AW-1:0]    ra;
  logic             b;

  assign issue_ok = IssueEn && addr_ok(int'(IssueRd), DEPTH, ZERO_REG != 0);

  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (WrOk[j] && (WrAddr[j*AW +: AW] == AW'(r))) busy_nxt[r] = 1'b0;
      end
      // A newly issued producer supersedes the result being written back.
      if (issue_ok && (IssueRd == AW'(r))) busy_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    RBusy = '0;
    ra    = '0;
    b     = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra = RAddr[i*AW +: AW];
      b  = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if (ra == AW'(r)) b = busy[r];
      end
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWRITE; j++) begin
        if (WrOk[j] && (WrAddr[j*AW +: AW] == ra)) b = issue_ok && (IssueRd == ra);
      end
`endif
      RBusy[i] = b && !Rst;
    end
  end

  assign AnyBusy = (|busy) && !Rst;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with fixed write priority and busy scoreboard.
// REGFILE_BYPASS_EN: same-cycle write-to-read bypass on RData/RBusy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NREAD*AW-1:0]     RAddr,
  output logic [NREAD*WIDTH-1:0]  RData,
  output logic [NREAD-1:0]        RBusy,
  input  logic [NWRITE-1:0]       WE,
  input  logic [NWRITE*AW-1:0]    WAddr,
  input  logic [NWRITE*WIDTH-1:0] WData,
  input  logic                    IssueEn,
  input  logic [AW-1:0]           IssueRd,
  output logic                    AnyBusy
);

  logic [WIDTH-1:0] mem    [DEPTH];
  logic [AW-1:0]    waddr  [NWRITE];
  logic [WIDTH-1:0] wdata  [NWRITE];
  logic [NWRITE-1:0] wr_ok;
  logic [AW-1:0]    raddr  [NREAD];
  logic [WIDTH-1:0] rd_v   [NREAD];

  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWRITE; j++) begin
      waddr[j] = WAddr[j*AW +: AW];
      wdata[j] = WData[j*WIDTH +: WIDTH];
      wr_ok[j] = WE[j] && addr_ok(int'(waddr[j]), DEPTH, ZERO_REG != 0);
    end
  end

  // Ports are applied in ascending order so the highest-index writer lands last and wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_ok[j] && (waddr[j] == AW'(r))) mem[r] <= wdata[j];
        end
      end
    end
  end

  always_comb begin
    RData = '0;
    for (int i = 0; i < NREAD; i++) begin
      raddr[i] = RAddr[i*AW +: AW];
      rd_v[i]  = '0;
      for (int r = 0; r < DEPTH; r++) begin
        if (raddr[i] == AW'(r)) rd_v[i] = mem[r];
      end
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_ok[j] && (waddr[j] == raddr[i])) rd_v[i] = wdata[j];
      end
`endif
      if (Rst) rd_v[i] = '0;
      RData[i*WIDTH +: WIDTH] = rd_v[i];
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .Clk     (Clk),
    .Rst     (Rst),
    .WrOk    (wr_ok),
    .WrAddr  (WAddr),
    .IssueEn (IssueEn),
    .IssueRd (IssueRd),
    .RAddr   (RAddr),
    .RBusy   (RBusy),
    .AnyBusy (AnyBusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with an array-based reference model checked every cycle.
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW    = 5;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [9:0]    RAddr = '0;
  logic [63:0]   RData;
  logic [1:0]    RBusy;
  logic [1:0]    WE = '0;
  logic [9:0]    WAddr = '0;
  logic [63:0]   WData = '0;
  logic          IssueEn = 1'b0;
  logic [4:0]    IssueRd = '0;
  logic          AnyBusy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_reg  [32];
  logic        m_busy [32];

  regfile_mp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NREAD    (2),
    .NWRITE   (2),
    .ZERO_REG (1)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .RAddr   (RAddr),
    .RData   (RData),
    .RBusy   (RBusy),
    .WE      (WE),
    .WAddr   (WAddr),
    .WData   (WData),
    .IssueEn (IssueEn),
    .IssueRd (IssueRd),
    .AnyBusy (AnyBusy)
  );

  always #10 Clk = ~Clk;

  function automatic bit valid(input int a);
    return (a < DEPTH) && (a != 0);
  endfunction

  // Reference model: architectural state updated once per clock edge.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int a = 0; a < 32; a++) begin
        m_reg[a]  = '0;
        m_busy[a] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (WE[j] && valid(int'(WAddr[j*AW +: AW]))) begin
          m_reg[int'(WAddr[j*AW +: AW])]  = WData[j*WIDTH +: WIDTH];
          m_busy[int'(WAddr[j*AW +: AW])] = 1'b0;
        end
      end
      if (IssueEn && valid(int'(IssueRd))) m_busy[int'(IssueRd)] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rdata(input int a);
    logic [31:0] v;
    if (Rst || !valid(a)) return '0;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (WE[j] && (int'(WAddr[j*AW +: AW]) == a)) v = WData[j*WIDTH +: WIDTH];
`endif
    return v;
  endfunction

  function automatic logic exp_rbusy(input int a);
    logic b;
    if (Rst || !valid(a)) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (WE[j] && (int'(WAddr[j*AW +: AW]) == a)) b = IssueEn && (int'(IssueRd) == a);
`endif
    return b;
  endfunction

  function automatic logic exp_any();
    logic b = 1'b0;
    if (Rst) return 1'b0;
    for (int a = 0; a < 32; a++) b = b | m_busy[a];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_rdata%0d", i), RData[i*WIDTH +: WIDTH], exp_rdata(int'(RAddr[i*AW +: AW])));
      chk($sformatf("model_rbusy%0d", i), 32'(RBusy[i]), 32'(exp_rbusy(int'(RAddr[i*AW +: AW]))));
    end
    chk("model_anybusy", 32'(AnyBusy), 32'(exp_any()));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    WE      = '0;
    IssueEn = 1'b0;
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    WE[port]                  = 1'b1;
    WAddr[port*AW +: AW]      = 5'(a);
    WData[port*WIDTH +: WIDTH] = d;
  endtask

  task automatic rd(input int port, input int a);
    RAddr[port*AW +: AW] = 5'(a);
  endtask

  initial begin
    step();
    step();
    chk("reset_rdata", RData[31:0], 32'h0);
    chk("reset_anybusy", 32'(AnyBusy), 32'h0);
    Rst = 1'b0;

    // Reset test: populate, then pulse reset between edges
    wr(0, 5, 32'hDEADBEEF);
    IssueEn = 1'b1; IssueRd = 5'd9;
    step(); idle();
    rd(0, 5); rd(1, 9);
    #1;
    chk("pre_reset_x5", RData[31:0], 32'hDEADBEEF);
    chk("pre_reset_busy9", 32'(RBusy[1]), 32'h1);
    Rst = 1'b1;
    #1;
    chk("async_reset_x5", RData[31:0], 32'h0);
    #2;
    Rst = 1'b0;
    #1;
    chk("post_reset_x5", RData[31:0], 32'h0);
    chk("post_reset_anybusy", 32'(AnyBusy), 32'h0);
    step();

    // Dual write
    wr(0, 3, 32'd7); wr(1, 4, 32'd9);
    step(); idle();
    rd(0, 3); rd(1, 4);
    #1;
    chk("dual_x3", RData[31:0], 32'd7);
    chk("dual_x4", RData[63:32], 32'd9);

    // Conflict: port 1 wins
    wr(0, 6, 32'h11); wr(1, 6, 32'h22);
    step(); idle();
    rd(0, 6);
    #1;
    chk("conflict_x6", RData[31:0], 32'h22);

    // Zero register
    wr(0, 0, 32'hFFFF_FFFF);
    IssueEn = 1'b1; IssueRd = 5'd0;
    step(); idle();
    rd(0, 0);
    #1;
    chk("zero_x0", RData[31:0], 32'h0);
    chk("zero_anybusy", 32'(AnyBusy), 32'h0);

    // Out of range ignored, last valid register works
    wr(0, 25, 32'h55); wr(1, 19, 32'h1919);
    IssueEn = 1'b1; IssueRd = 5'd25;
    step(); idle();
    rd(0, 25); rd(1, 19);
    #1;
    chk("oor_rdata", RData[31:0], 32'h0);
    chk("oor_rbusy", 32'(RBusy[0]), 32'h0);
    chk("oor_anybusy", 32'(AnyBusy), 32'h0);
    chk("last_x19", RData[63:32], 32'h1919);

    // Scoreboard
    IssueEn = 1'b1; IssueRd = 5'd7;
    step(); idle();
    rd(0, 7);
    #1;
    chk("sb_issue_busy", 32'(RBusy[0]), 32'h1);
    chk("sb_issue_any", 32'(AnyBusy), 32'h1);
    wr(0, 7, 32'h77);
    step(); idle();
    #1;
    chk("sb_clear_busy", 32'(RBusy[0]), 32'h0);
    chk("sb_clear_data", RData[31:0], 32'h77);
    wr(1, 7, 32'h78);
    IssueEn = 1'b1; IssueRd = 5'd7;
    step(); idle();
    #1;
    chk("sb_setwins_busy", 32'(RBusy[0]), 32'h1);
    chk("sb_setwins_data", RData[31:0], 32'h78);
    IssueEn = 1'b1; IssueRd = 5'd7;
    step(); idle();
    wr(0, 7, 32'h79);
    step(); idle();
    #1;
    chk("sb_nocount_busy", 32'(RBusy[0]), 32'h0);
    chk("sb_nocount_any", 32'(AnyBusy), 32'h0);

    // Bypass / read-after-write latency
    wr(0, 8, 32'h80);
    step(); idle();
    wr(0, 8, 32'd42);
    rd(0, 8);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("raw_same_cycle", RData[31:0], 32'd42);
`else
    chk("raw_same_cycle", RData[31:0], 32'h80);
`endif
    step(); idle();
    #1;
    chk("raw_next_cycle", RData[31:0], 32'd42);

    // Mixed burst, checked by the model every cycle
    for (int k = 0; k < 24; k++) begin
      WE      = 2'(k);
      WAddr   = {5'((k * 5 + 1) % 22), 5'((k * 3) % 22)};
      WData   = {~(32'(k) * 32'h0101_0101), 32'(k) * 32'h0101_0101};
      IssueEn = k[0];
      IssueRd = 5'((k * 7) % 22);
      RAddr   = {5'((k * 7) % 22), 5'((k * 3 + 3) % 22)};
      step();
    end
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
